// File: rtl/end_banner_pkg.sv
// End-of-game banner: shared status codes, FSM states and palette.
package end_banner_pkg;

  localparam logic [3:0] WIN_STATUS  = 4'd6;
  localparam logic [3:0] LOSE_STATUS = 4'd7;
  localparam int         ADDR_W      = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REVEAL,
    ST_HOLD
  } banner_state_e;

  // Index 0 sits in the low slice: black, grey, red, white.
  localparam logic [3:0][23:0] PALETTE = {
    24'hffffff,
    24'hff0000,
    24'h818181,
    24'h000000
  };

endpackage

// File: rtl/end_banner_rom.sv
// Combined win+lose sprite store: address -> palette index -> RGB.
module banner_rom
  import end_banner_pkg::*;
#(
  parameter int BANNER_W = 292,
  parameter int BANNER_H = 36
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [23:0]       color
);

  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(BANNER_W * BANNER_H);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(2 * BANNER_W * BANNER_H);

  logic [3:0] pal_idx;

  // Win half striped white/grey, lose half red/grey.
  always_comb begin
    pal_idx = 4'd0;
    if (addr < FRAME)
      pal_idx = addr[3] ? 4'd3 : 4'd1;
    else if (addr < DEPTH)
      pal_idx = addr[3] ? 4'd2 : 4'd1;
  end

  always_comb begin
    color = 24'h000000;
    if (pal_idx < 4'd4)
      color = PALETTE[pal_idx[1:0]];
  end

endmodule

// File: rtl/end_banner.sv
// Win/lose banner: column-wise reveal per frame, then optional blinking hold.
module end_banner
  import end_banner_pkg::*;
#(
  parameter int         BANNER_W     = 292,
  parameter int         BANNER_H     = 36,
  parameter int         X0           = 174,
  parameter int         Y0           = 222,
  parameter logic [3:0] WIN_CODE     = WIN_STATUS,
  parameter logic [3:0] LOSE_CODE    = LOSE_STATUS,
  parameter int         REVEAL_STEP  = 8,
  parameter int         BLINK_EN     = 1,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [3:0]        status,
  output logic              is_banner,
  output logic [ADDR_W-1:0] banner_address,
  output logic              banner_sel,
  output logic              reveal_done,
  output logic [23:0]       banner_color
);

  localparam int CW = $clog2(BANNER_W + REVEAL_STEP + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] COLS_MAX = CW'(BANNER_W);
  localparam logic [CW-1:0] STEP     = CW'(REVEAL_STEP);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [ADDR_W-1:0] X_LO  = ADDR_W'(X0);
  localparam logic [ADDR_W-1:0] X_HI  = ADDR_W'(X0 + BANNER_W);
  localparam logic [ADDR_W-1:0] Y_LO  = ADDR_W'(Y0);
  localparam logic [ADDR_W-1:0] Y_HI  = ADDR_W'(Y0 + BANNER_H);
  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(BANNER_W);
  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(BANNER_W * BANNER_H);

  logic fs1, fs2, fs3;
  logic sync_live, sync_armed;
  logic frame_tick;

  // Arming needs a real low seen after reset, so a high frame_clk
  // at release cannot masquerade as a rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1        <= 1'b0;
      fs2        <= 1'b0;
      fs3        <= 1'b0;
      sync_live  <= 1'b0;
      sync_armed <= 1'b0;
    end else begin
      fs1       <= frame_clk;
      fs2       <= fs1;
      fs3       <= fs2;
      sync_live <= 1'b1;
      if (sync_live && !fs1)
        sync_armed <= 1'b1;
    end
  end

  assign frame_tick = fs2 & ~fs3 & sync_armed;

  banner_state_e state;
  logic [CW-1:0] reveal_cols;
  logic [CW-1:0] cols_next;
  logic [BW-1:0] blink_cnt;
  logic          visible;
  logic          is_win, is_lose, code_hit, restart;

  assign is_win    = (status == WIN_CODE);
  assign is_lose   = (status == LOSE_CODE);
  assign code_hit  = is_win | is_lose;
  assign restart   = (state == ST_IDLE) || (is_lose != banner_sel);
  assign cols_next = reveal_cols + STEP;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      reveal_cols <= '0;
      blink_cnt   <= '0;
      visible     <= 1'b1;
      banner_sel  <= 1'b0;
    end else if (!code_hit) begin
      state <= ST_IDLE;
    end else if (restart) begin
      state       <= ST_REVEAL;
      banner_sel  <= is_lose;
      reveal_cols <= '0;
      blink_cnt   <= '0;
      visible     <= 1'b1;
    end else if (frame_tick) begin
      case (state)
        ST_REVEAL: begin
          if (cols_next >= COLS_MAX) begin
            reveal_cols <= COLS_MAX;
            state       <= ST_HOLD;
            blink_cnt   <= '0;
            visible     <= 1'b1;
          end else begin
            reveal_cols <= cols_next;
          end
        end
        ST_HOLD: begin
          if (BLINK_EN != 0) begin
            if (blink_cnt == BLK_LAST) begin
              blink_cnt <= '0;
              visible   <= ~visible;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [ADDR_W-1:0] px, py, dx, dy, addr;
  logic              hit;

  always_comb begin
    px   = ADDR_W'(DrawX);
    py   = ADDR_W'(DrawY);
    dx   = px - X_LO;
    dy   = py - Y_LO;
    addr = dx + dy * W_A + (banner_sel ? FRAME : '0);
    hit  = (px >= X_LO) && (px < X_HI) &&
           (py >= Y_LO) && (py < Y_HI) &&
           (dx < ADDR_W'(reveal_cols)) &&
           (state != ST_IDLE) &&
           ((state != ST_HOLD) || visible);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_banner      <= 1'b0;
      banner_address <= '0;
      reveal_done    <= 1'b0;
    end else begin
      is_banner      <= hit;
      banner_address <= hit ? addr : '0;
      reveal_done    <= (state == ST_HOLD);
    end
  end

  banner_rom #(
    .BANNER_W (BANNER_W),
    .BANNER_H (BANNER_H)
  ) u_rom (
    .addr  (banner_address),
    .color (banner_color)
  );

endmodule

// File: tb/tb_end_banner.sv
// Randomised bench for end_banner against a tick-count reference model.
module tb_end_banner;

  localparam int W       = 292;
  localparam int H       = 36;
  localparam int X0      = 174;
  localparam int Y0      = 222;
  localparam int STEP    = 8;
  localparam int BF      = 30;
  localparam int HOLD_AT = (W + STEP - 1) / STEP;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [3:0]  status = '0;
  logic        is_banner;
  logic [19:0] banner_address;
  logic        banner_sel;
  logic        reveal_done;
  logic [23:0] banner_color;

  end_banner dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .status         (status),
    .is_banner      (is_banner),
    .banner_address (banner_address),
    .banner_sel     (banner_sel),
    .reveal_done    (reveal_done),
    .banner_color   (banner_color)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  bit m_active = 1'b0;
  bit m_sel    = 1'b0;
  int m_ticks  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_cols();
    int c;
    c = m_ticks * STEP;
    if (!m_active) return 0;
    return (c > W) ? W : c;
  endfunction

  function automatic bit m_hold();
    return m_active && (m_ticks >= HOLD_AT);
  endfunction

  function automatic bit m_visible();
    if (!m_hold()) return 1'b1;
    return (((m_ticks - HOLD_AT) / BF) % 2) == 0;
  endfunction

  task automatic probe(input string tag, input int x, input int y);
    bit h;
    int a;
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    h = m_active && x >= X0 && x < X0 + W &&
        y >= Y0 && y < Y0 + H &&
        (x - X0) < m_cols() && m_visible();
    a = h ? (x - X0) + (y - Y0) * W + (m_sel ? W * H : 0) : 0;
    @(posedge Clk);
    #1;
    check({tag, ".hit"},  32'(is_banner),      32'(h));
    check({tag, ".addr"}, 32'(banner_address), 32'(a));
    check({tag, ".sel"},  32'(banner_sel),     32'(m_sel));
    check({tag, ".done"}, 32'(reveal_done),    32'(m_hold()));
  endtask

  task automatic tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    if (m_active) m_ticks++;
  endtask

  task automatic set_status(input logic [3:0] s);
    bit nsel;
    @(negedge Clk);
    status = s;
    nsel = (s == 4'd7);
    if (s == 4'd6 || s == 4'd7) begin
      if (!m_active || nsel != m_sel) begin
        m_active = 1'b1;
        m_sel    = nsel;
        m_ticks  = 0;
      end
    end else begin
      m_active = 1'b0;
    end
  endtask

  task automatic rand_probes(input int n);
    for (int i = 0; i < n; i++)
      probe("rnd", X0 - 4 + int'($urandom_range(0, W + 8)),
                   Y0 - 3 + int'($urandom_range(0, H + 6)));
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("reset.hit",  32'(is_banner),      0);
    check("reset.addr", 32'(banner_address), 0);
    check("reset.sel",  32'(banner_sel),     0);
    check("reset.done", 32'(reveal_done),    0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    set_status(4'd6);
    probe("start", X0, Y0);
    for (int t = 1; t <= HOLD_AT; t++) begin
      tick();
      probe("edge_in", X0 + m_cols() - 1, Y0);
      probe("edge_out", X0 + m_cols(), Y0);
      if (t == 2) begin
        probe("x189", 189, 222);
        check("x189.addr15", 32'(banner_address), 15);
        probe("x190", 190, 222);
        check("x190.miss", 32'(is_banner), 0);
      end
      rand_probes(2);
    end
    check("win.done", 32'(reveal_done), 1);
    probe("corner", X0 + W - 1, Y0 + H - 1);

    for (int t = 1; t <= 2 * BF; t++) begin
      tick();
      probe("blink", X0 + 10, Y0 + 5);
      if (t == BF) check("blink.off", 32'(is_banner), 0);
      if (t == 2 * BF) check("blink.on", 32'(is_banner), 1);
    end

    set_status(4'd7);
    probe("lose.start", X0, Y0);
    for (int t = 1; t <= HOLD_AT; t++) begin
      tick();
      rand_probes(1);
    end
    probe("lose.addr", 174, 223);
    check("lose.10804", 32'(banner_address), 10804);

    set_status(4'd6);
    repeat (3) tick();
    probe("mid.win", X0 + 20, Y0 + 2);
    set_status(4'd7);
    probe("mid.cleared", X0, Y0);
    repeat (2) tick();
    probe("mid.rerev", X0 + 15, Y0 + 1);
    probe("mid.rerev_out", X0 + 16, Y0 + 1);

    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    status = 4'd0;
    m_active = 1'b0;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    probe("idle", X0 + 1, Y0);
    check("idle.nohit", 32'(is_banner), 0);

    set_status(4'd6);
    probe("again.start", X0, Y0);
    tick();
    probe("again.in", X0 + 7, Y0);

    set_status(4'd7);
    repeat (3) tick();
    probe("pre_rst", X0 + 3, Y0 + 1);
    check("pre_rst.hit", 32'(is_banner), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst.hit",  32'(is_banner),      0);
    check("rst.addr", 32'(banner_address), 0);
    check("rst.sel",  32'(banner_sel),     0);
    check("rst.done", 32'(reveal_done),    0);
    m_active = 1'b0;
    m_sel    = 1'b0;
    m_ticks  = 0;
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_active = 1'b1;
    m_sel    = 1'b1;
    repeat (8) @(negedge Clk);
    probe("no_tick", X0, Y0);
    probe("no_tick1", X0 + 1, Y0 + 1);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    tick();
    probe("post.in", X0 + 7, Y0);
    probe("post.out", X0 + 8, Y0);
    rand_probes(8);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
